// File: rtl/cpu_store_drain_if.sv
// Memory-bus write channel between the store drain (master) and the memory side (slave).
// One outstanding write at a time; completion is signalled by bus_ack or bus_err.
interface cpu_store_drain_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic              bus_err;

  modport master (
    output bus_req, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_err
  );

  modport slave (
    input  bus_req, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_err
  );
endinterface

// File: rtl/cpu_store_drain.sv
// Drains a store FIFO onto a single-outstanding memory write bus, with error/timeout capture.
// bus_req rises 2 cycles after a pop; hold or a busy bus stalls pops, and the FIFO simply fills.
module cpu_store_drain #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int ENTRY_W = 4 + ADDR_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty_i,
  input  logic [ENTRY_W-1:0] fifo_dout_i,
  output logic               fifo_rd_en_o,
  input  logic               hold_i,
  cpu_store_drain_if.master  bus,
  output logic               busy_o,
  output logic               err_flag_o,
  output logic               to_flag_o,
  output logic [ADDR_W-1:0]  err_addr_o,
  input  logic               err_clr_i,
  output logic [15:0]        drain_cnt_o
);
  typedef enum logic [1:0] {IDLE, POP, REQ} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              err_flag_q, err_flag_d;
  logic              to_flag_q, to_flag_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [15:0]       drain_cnt_q, drain_cnt_d;
  logic [15:0]       tcnt_q, tcnt_d;

  logic in_req, resp, timeout_hit;

  // Responses only count while a request is actually outstanding.
  assign in_req       = (state_q == REQ);
  assign resp         = in_req && (bus.bus_ack || bus.bus_err);
  assign timeout_hit  = in_req && !resp && (tcnt_q == 16'(TIMEOUT - 1));
  assign fifo_rd_en_o = !fifo_empty_i && !hold_i && ((state_q == IDLE) || resp || timeout_hit);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    err_flag_d  = err_flag_q;
    to_flag_d   = to_flag_q;
    err_addr_d  = err_addr_q;
    drain_cnt_d = drain_cnt_q;
    tcnt_d      = tcnt_q;

    // Clear first so a same-cycle error below re-sets the flag.
    if (err_clr_i) begin
      err_flag_d = 1'b0;
      to_flag_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (fifo_rd_en_o) state_d = POP;
      end
      POP: begin
        {be_d, addr_d, wdata_d} = fifo_dout_i;
        req_d   = 1'b1;
        tcnt_d  = '0;
        state_d = REQ;
      end
      REQ: begin
        if (bus.bus_err) begin
          err_flag_d = 1'b1;
          err_addr_d = addr_q;
        end else if (bus.bus_ack) begin
          drain_cnt_d = drain_cnt_q + 16'd1;
        end else if (timeout_hit) begin
          to_flag_d  = 1'b1;
          err_addr_d = addr_q;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
        if (resp || timeout_hit) begin
          req_d   = 1'b0;
          state_d = fifo_rd_en_o ? POP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_flag_q  <= 1'b0;
      to_flag_q   <= 1'b0;
      err_addr_q  <= '0;
      drain_cnt_q <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      err_flag_q  <= err_flag_d;
      to_flag_q   <= to_flag_d;
      err_addr_q  <= err_addr_d;
      drain_cnt_q <= drain_cnt_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;
  assign busy_o        = (state_q != IDLE) || !fifo_empty_i;
  assign err_flag_o    = err_flag_q;
  assign to_flag_o     = to_flag_q;
  assign err_addr_o    = err_addr_q;
  assign drain_cnt_o   = drain_cnt_q;
endmodule

// File: tb/tb_cpu_store_drain.sv
// Directed bench for cpu_store_drain: behavioural registered-output FIFO plus a response driver.
module tb_cpu_store_drain;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty, fifo_rd_en, hold, busy, err_flag, to_flag, err_clr;
  logic [67:0] fifo_dout;
  logic [31:0] err_addr;
  logic [15:0] drain_cnt;

  always #5 clk = ~clk;

  cpu_store_drain_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  cpu_store_drain #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty),
    .fifo_dout_i  (fifo_dout),
    .fifo_rd_en_o (fifo_rd_en),
    .hold_i       (hold),
    .bus          (bus_if),
    .busy_o       (busy),
    .err_flag_o   (err_flag),
    .to_flag_o    (to_flag),
    .err_addr_o   (err_addr),
    .err_clr_i    (err_clr),
    .drain_cnt_o  (drain_cnt)
  );

  // Store FIFO model: data appears the cycle after a pop.
  logic [67:0] mem [16];
  int          wr_ptr, rd_ptr, viol;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= 0;
      viol      <= 0;
      fifo_dout <= '0;
    end else if (fifo_rd_en) begin
      if (fifo_empty) viol <= viol + 1;
      fifo_dout <= mem[rd_ptr & 15];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  logic [31:0] acked [$];
  always @(posedge clk)
    if (!rst && bus_if.bus_req && bus_if.bus_ack && !bus_if.bus_err)
      acked.push_back(bus_if.bus_addr);

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] mk(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    return {be, a, d};
  endfunction

  task automatic push(input logic [67:0] e);
    mem[wr_ptr & 15] = e;
    wr_ptr++;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (bus_if.bus_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " req seen"}, 64'(bus_if.bus_req), 64'd1);
  endtask

  typedef struct {
    logic        ack;
    logic        exp_rd_en;
    logic        exp_req;
    logic        exp_busy;
    logic [15:0] exp_drain;
  } vec_t;

  vec_t        vecs [7];
  logic [9:0]  pat;
  int          hi;

  initial begin
    // Single entry, ack in the 4th request cycle (also the timeout cycle: response wins).
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1};

    rst = 1'b1; hold = 1'b0; err_clr = 1'b0; wr_ptr = 0;
    bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst bus_req", 64'(bus_if.bus_req), 64'd0);
    check("rst bus_addr", 64'(bus_if.bus_addr), 64'd0);
    check("rst drain_cnt", 64'(drain_cnt), 64'd0);
    check("rst flags", 64'({err_flag, to_flag}), 64'd0);
    check("rst err_addr", 64'(err_addr), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    rst = 1'b0;

    push(mk(4'hF, 32'h100, 32'hDEADBEEF));
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      bus_if.bus_ack = vecs[i].ack;
      #1;
      check($sformatf("v%0d rd_en", i), 64'(fifo_rd_en), 64'(vecs[i].exp_rd_en));
      check($sformatf("v%0d bus_req", i), 64'(bus_if.bus_req), 64'(vecs[i].exp_req));
      check($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      check($sformatf("v%0d drain_cnt", i), 64'(drain_cnt), 64'(vecs[i].exp_drain));
      if (i == 2) begin
        check("payload addr", 64'(bus_if.bus_addr), 64'h100);
        check("payload data", 64'(bus_if.bus_wdata), 64'hDEADBEEF);
        check("payload be", 64'(bus_if.bus_be), 64'hF);
      end
    end
    check("v to_flag", 64'(to_flag), 64'd0);

    // Four entries, ack in the same cycle as req: back-to-back pops.
    @(negedge clk);
    acked.delete();
    for (int k = 0; k < 4; k++) push(mk(4'h3, 32'(32'h10 * (k + 1)), 32'(k)));
    pat = '0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      bus_if.bus_ack = bus_if.bus_req;
      #1;
      pat[c] = bus_if.bus_req;
    end
    check("b2b req pattern", 64'(pat), 64'(10'b0101010100));
    check("b2b drain_cnt", 64'(drain_cnt), 64'd5);
    check("b2b ack count", 64'(acked.size()), 64'd4);
    if (acked.size() == 4) begin
      check("b2b order0", 64'(acked[0]), 64'h10);
      check("b2b order3", 64'(acked[3]), 64'h40);
    end
    check("b2b pop when empty", 64'(viol), 64'd0);

    // Bus error (err and ack together: err wins), then clear.
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    push(mk(4'hF, 32'h200, 32'h55));
    wait_req("err");
    bus_if.bus_err = 1'b1; bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_err = 1'b0; bus_if.bus_ack = 1'b0;
    #1;
    check("err flag", 64'(err_flag), 64'd1);
    check("err addr", 64'(err_addr), 64'h200);
    check("err drain", 64'(drain_cnt), 64'd5);
    check("err to_flag", 64'(to_flag), 64'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("err cleared", 64'(err_flag), 64'd0);

    // Clear and new error in the same cycle: set wins.
    push(mk(4'hF, 32'h240, 32'h66));
    wait_req("setwin");
    bus_if.bus_err = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    bus_if.bus_err = 1'b0; err_clr = 1'b0;
    #1;
    check("setwin flag", 64'(err_flag), 64'd1);
    check("setwin addr", 64'(err_addr), 64'h240);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Timeout: req held exactly TIMEOUT cycles, next entry popped in the timeout cycle.
    push(mk(4'h1, 32'h300, 32'h77));
    push(mk(4'h2, 32'h340, 32'h88));
    wait_req("to");
    hi = 0;
    while (bus_if.bus_req === 1'b1 && hi < 10) begin
      hi++;
      #1;
      if (hi == 4) check("to pop in timeout cycle", 64'(fifo_rd_en), 64'd1);
      @(negedge clk);
    end
    #1;
    check("to req cycles", 64'(hi), 64'd4);
    check("to flag", 64'(to_flag), 64'd1);
    check("to err_flag", 64'(err_flag), 64'd0);
    check("to err_addr", 64'(err_addr), 64'h300);
    wait_req("to next");
    check("to next addr", 64'(bus_if.bus_addr), 64'h340);
    hold = 1'b1;
    @(negedge clk);
    #1;
    check("hold keeps req", 64'(bus_if.bus_req), 64'd1);
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0; hold = 1'b0; err_clr = 1'b1;
    #1;
    check("to next drain", 64'(drain_cnt), 64'd6);
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("to cleared", 64'(to_flag), 64'd0);

    // Hold blocks pops; release drains both in order.
    acked.delete();
    hold = 1'b1;
    push(mk(4'hF, 32'h400, 32'h1));
    push(mk(4'hF, 32'h440, 32'h2));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("hold%0d rd_en", c), 64'(fifo_rd_en), 64'd0);
      check($sformatf("hold%0d busy", c), 64'(busy), 64'd1);
    end
    @(negedge clk);
    hold = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      bus_if.bus_ack = bus_if.bus_req;
      #1;
    end
    bus_if.bus_ack = 1'b0;
    check("hold ack count", 64'(acked.size()), 64'd2);
    if (acked.size() == 2) begin
      check("hold order0", 64'(acked[0]), 64'h400);
      check("hold order1", 64'(acked[1]), 64'h440);
    end
    check("hold drain", 64'(drain_cnt), 64'd8);
    check("pop when empty", 64'(viol), 64'd0);

    // Reset between edges while a request is outstanding.
    @(negedge clk);
    push(mk(4'hF, 32'h500, 32'h9));
    wait_req("rst");
    #2;
    rst = 1'b1; wr_ptr = 0;
    #1;
    check("midrst bus_req", 64'(bus_if.bus_req), 64'd0);
    check("midrst bus_addr", 64'(bus_if.bus_addr), 64'd0);
    check("midrst drain", 64'(drain_cnt), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    push(mk(4'hF, 32'h600, 32'hA));
    #1;
    check("post rst rd_en", 64'(fifo_rd_en), 64'd1);
    wait_req("post rst");
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    check("post rst drain", 64'(drain_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
